// File: rtl/dq_sched_pkg.sv
// Shared types and default timing for the DQ column-command scheduler.
package dq_sched_pkg;

  typedef enum logic {MODE_RD, MODE_WR} dq_mode_e;

  localparam int DEF_BG_WIDTH     = 2;
  localparam int DEF_BK_WIDTH     = 2;
  localparam int DEF_COL_WIDTH    = 10;
  localparam int DEF_TWTR         = 10;
  localparam int DEF_TRTW         = 8;
  localparam int DEF_STARVE_LIMIT = 16;

  typedef struct packed {
    logic [DEF_BG_WIDTH-1:0]  bg;
    logic [DEF_BK_WIDTH-1:0]  bk;
    logic [DEF_COL_WIDTH-1:0] col;
  } cas_req_t;

endpackage

// File: rtl/turnaround_counter.sv
// Loadable saturating down-counter; zero means the turnaround gap has elapsed.
module turnaround_counter #(
  parameter int LOAD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);
  localparam int W = (LOAD > 1) ? $clog2(LOAD) : 1;

  logic [W-1:0] cnt;

  // Loading LOAD-1 at the issue edge makes the opposite CAS legal exactly LOAD cycles later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               cnt <= '0;
    else if (load)          cnt <= W'(LOAD - 1);
    else if (cnt != '0)     cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dq_cas_issue_arbiter.sv
// Picks the next RD/WR CAS for one channel: mode scheduling, turnaround, anti-starvation.
module dq_cas_issue_arbiter
  import dq_sched_pkg::*;
#(
  parameter int BG_WIDTH     = DEF_BG_WIDTH,
  parameter int BK_WIDTH     = DEF_BK_WIDTH,
  parameter int COL_WIDTH    = DEF_COL_WIDTH,
  parameter int tWTR         = DEF_TWTR,
  parameter int tRTW         = DEF_TRTW,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdReqValid,
  input  logic [BG_WIDTH-1:0]  rdReqBG,
  input  logic [BK_WIDTH-1:0]  rdReqBK,
  input  logic [COL_WIDTH-1:0] rdReqCol,
  output logic                 rdReqReady,
  input  logic                 wrReqValid,
  input  logic [BG_WIDTH-1:0]  wrReqBG,
  input  logic [BK_WIDTH-1:0]  wrReqBK,
  input  logic [COL_WIDTH-1:0] wrReqCol,
  output logic                 wrReqReady,
  input  logic                 wrDrainReq,
  input  logic                 chRdWrAvailable,
  output logic                 chRdWrACK,
  output logic                 CCDType,
  output logic                 casValid,
  output logic                 casIsWrite,
  output logic [BG_WIDTH-1:0]  casBG,
  output logic [BK_WIDTH-1:0]  casBK,
  output logic [COL_WIDTH-1:0] casCol
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [BG_WIDTH-1:0]  bg;
    logic [BK_WIDTH-1:0]  bk;
    logic [COL_WIDTH-1:0] col;
  } cas_t;

  dq_mode_e      mode, mode_nxt;
  logic [SW-1:0] starve_cnt;
  logic          at_limit, switch_mode, rd_fire, wr_fire, fire, opp_valid;
  logic          last_valid, cas_vld, cas_wr;
  logic [BG_WIDTH-1:0] last_bg, fire_bg;
  cas_t          cas_q;
  logic [1:0]    ta_load, ta_zero;

  // Index 0: write-to-read gap (tWTR), index 1: read-to-write gap (tRTW).
  assign ta_load = {rd_fire, wr_fire};

  for (genvar g = 0; g < 2; g++) begin : g_ta
    turnaround_counter #(.LOAD(g == 0 ? tWTR : tRTW)) u_ta (
      .clk  (clk),
      .rst  (rst),
      .load (ta_load[g]),
      .zero (ta_zero[g])
    );
  end

  assign at_limit = (starve_cnt == SW'(STARVE_LIMIT));

  // A pending switch always wins the cycle; the mode flips at the next edge.
  always_comb begin
    switch_mode = 1'b0;
    rd_fire     = 1'b0;
    wr_fire     = 1'b0;
    case (mode)
      MODE_RD: begin
        switch_mode = wrReqValid && (wrDrainReq || !rdReqValid || at_limit);
        rd_fire     = rst && !switch_mode && rdReqValid && chRdWrAvailable && ta_zero[0];
      end
      MODE_WR: begin
        switch_mode = rdReqValid && (!wrReqValid || !wrDrainReq || at_limit);
        wr_fire     = rst && !switch_mode && wrReqValid && chRdWrAvailable && ta_zero[1];
      end
      default: ;
    endcase
    mode_nxt = mode;
    if (switch_mode) mode_nxt = (mode == MODE_RD) ? MODE_WR : MODE_RD;
  end

  assign fire       = rd_fire | wr_fire;
  assign fire_bg    = wr_fire ? wrReqBG : rdReqBG;
  assign opp_valid  = wr_fire ? rdReqValid : wrReqValid;
  assign rdReqReady = rd_fire;
  assign wrReqReady = wr_fire;
  assign chRdWrACK  = fire;
  assign CCDType    = fire && (!last_valid || (fire_bg != last_bg));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode       <= MODE_RD;
      starve_cnt <= '0;
      last_valid <= 1'b0;
      last_bg    <= '0;
      cas_vld    <= 1'b0;
      cas_wr     <= 1'b0;
      cas_q      <= '0;
    end else begin
      mode    <= mode_nxt;
      cas_vld <= fire;
      if (mode_nxt != mode)                   starve_cnt <= '0;
      else if (fire && opp_valid && !at_limit) starve_cnt <= starve_cnt + SW'(1);
      if (fire) begin
        last_valid <= 1'b1;
        last_bg    <= fire_bg;
        cas_wr     <= wr_fire;
        cas_q      <= wr_fire ? cas_t'{wrReqBG, wrReqBK, wrReqCol}
                              : cas_t'{rdReqBG, rdReqBK, rdReqCol};
      end
    end
  end

  assign casValid   = cas_vld;
  assign casIsWrite = cas_wr;
  assign casBG      = cas_q.bg;
  assign casBK      = cas_q.bk;
  assign casCol     = cas_q.col;

endmodule
